// File: rtl/tq_row_arb_mux.sv
// -----------------------------------------------------------------------------
// tq_row_arb_mux
//
// Two-source row multiplexer for the transform/quantisation datapath. Source 0
// carries full-width transform-stage rows. Source 1 carries narrow PE rows,
// which are sign-extended to the output width. Both sources are arbitrated
// onto a single registered output row stage with valid/ready flow control.
// Per-source row counters mark the last row of each source's block.
//
// Parameters
//   LANES  coefficients per row
//   WA     source-0 / output coefficient width (signed)
//   WB     source-1 coefficient width (signed), WB <= WA
//   ROWS   rows per block per source (>= 2)
//   RR     0 = source 0 fixed priority, 1 = round-robin
//
// Ports
//   clk       clock
//   rst       asynchronous active-high reset
//   i_valid0  source-0 row valid
//   i_ready0  source-0 row accepted this cycle (with i_valid0)
//   i_data0   source-0 row, lane k at [k*WA +: WA]
//   i_valid1  source-1 row valid
//   i_ready1  source-1 row accepted this cycle (with i_valid1)
//   i_data1   source-1 row, lane k at [k*WB +: WB]
//   o_valid   output row valid
//   o_ready   downstream accepts the output row
//   o_data    output row, lane k at [k*WA +: WA]
//   o_src     source of the current output row
//   o_last    current output row is row ROWS-1 of its source's block
// -----------------------------------------------------------------------------
module tq_row_arb_mux #(
  parameter int LANES = 32,
  parameter int WA    = 19,
  parameter int WB    = 16,
  parameter int ROWS  = 32,
  parameter int RR    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid0,
  output logic                i_ready0,
  input  logic [LANES*WA-1:0] i_data0,
  input  logic                i_valid1,
  output logic                i_ready1,
  input  logic [LANES*WB-1:0] i_data1,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [LANES*WA-1:0] o_data,
  output logic                o_src,
  output logic                o_last
);

  localparam int            CW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  // Output row stage
  logic                o_valid_q, o_valid_d;
  logic [LANES*WA-1:0] o_data_q,  o_data_d;
  logic                o_src_q,   o_src_d;
  logic                o_last_q,  o_last_d;

  // Per-source block position and round-robin pointer (1 = favour source 1)
  logic [CW-1:0]       cnt0_q, cnt0_d;
  logic [CW-1:0]       cnt1_q, cnt1_d;
  logic                fav1_q, fav1_d;

  logic                load;
  logic                grant0, grant1;
  logic [LANES*WA-1:0] data1_ext;

  // The output stage can take a new row when it is empty or draining now.
  assign load = !o_valid_q || o_ready;

  // Source 1 wins only when it is alone, or in round-robin mode when source 0
  // took the previous accepted beat.
  assign grant0 = i_valid0 && (!i_valid1 || (RR == 0) || !fav1_q);
  assign grant1 = i_valid1 && !grant0;

  // Ready is forced low during reset: the output stage looks empty then, so
  // load alone would otherwise report readiness.
  assign i_ready0 = load && grant0 && !rst;
  assign i_ready1 = load && grant1 && !rst;

  // Sign-extend each narrow lane: fill with the sign bit, then overlay the
  // original bits. This form also stays legal when WA == WB.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    data1_ext = '0;
    for (int k = 0; k < LANES; k++) begin
      data1_ext[k*WA +: WA]   = {WA{i_data1[k*WB + WB - 1]}};
      data1_ext[k*WA +: WB]   = i_data1[k*WB +: WB];
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_src_d   = o_src_q;
    o_last_d  = o_last_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    fav1_d    = fav1_q;

    if (load) begin
      o_valid_d = grant0 || grant1;
      if (grant0) begin
        o_data_d = i_data0;
        o_src_d  = 1'b0;
        o_last_d = (cnt0_q == LAST_ROW);
        cnt0_d   = (cnt0_q == LAST_ROW) ? '0 : cnt0_q + 1'b1;
        fav1_d   = 1'b1;
      end else if (grant1) begin
        o_data_d = data1_ext;
        o_src_d  = 1'b1;
        o_last_d = (cnt1_q == LAST_ROW);
        cnt1_d   = (cnt1_q == LAST_ROW) ? '0 : cnt1_q + 1'b1;
        fav1_d   = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      // NOTE: the wide data register is reset too, so a dropped row can never
      // reappear and the output is deterministic from reset.
      o_data_q  <= '0;
      o_src_q   <= 1'b0;
      o_last_q  <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      fav1_q    <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_src_q   <= o_src_d;
      o_last_q  <= o_last_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      fav1_q    <= fav1_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_src   = o_src_q;
  assign o_last  = o_last_q;

endmodule
